sync_tx_scheduler: RTL and testbench



---
 rtl/sync_tx_scheduler.sv | 140 ++++++++++++++
 tb/tb_sync_tx_scheduler.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/sync_tx_scheduler.sv
// rtl/sync_tx_scheduler.sv - arbitrated launcher for a shared DATA_SYNC bus crossing
//
// Purpose: picks one of NUM_REQ requesters, registers its word onto UN_SYNC_BUS,
// fires a one-cycle BUS_EN/GNT and then holds the bus for HOLD_CYCLES cycles so the
// destination synchroniser can sample it safely.
// Build option: SYNC_SCHED_FIXED_PRIO_EN selects fixed priority (lowest index wins)
// instead of the default round-robin arbiter.
//
// Ports:
//   CLK          in   source-domain clock
//   RST          in   asynchronous reset, active-high
//   REQ          in   [NUM_REQ]            per-requester level request
//   DATA_IN      in   [NUM_REQ*BUS_WIDTH]  requester i word at [i*BUS_WIDTH +: BUS_WIDTH]
//   GNT          out  [NUM_REQ]            one-hot single-cycle accept pulse
//   UN_SYNC_BUS  out  [BUS_WIDTH]          registered word towards DATA_SYNC
//   BUS_EN       out                       single-cycle launch pulse towards DATA_SYNC
//   BUSY         out                       high while the bus is being held
module sync_tx_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int BUS_WIDTH   = 8,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [NUM_REQ-1:0]           REQ,
  input  logic [NUM_REQ*BUS_WIDTH-1:0] DATA_IN,
  output logic [NUM_REQ-1:0]           GNT,
  output logic [BUS_WIDTH-1:0]         UN_SYNC_BUS,
  output logic                         BUS_EN,
  output logic                         BUSY
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t               state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [PTR_W-1:0]     win_idx;
  logic                 win_valid;
  logic [NUM_REQ-1:0]   gnt_n;
  logic [BUS_WIDTH-1:0] bus_n;
  logic                 bus_en_n;
  logic                 busy_n;

`ifndef SYNC_SCHED_FIXED_PRIO_EN
  logic [PTR_W-1:0]     rr_ptr, rr_ptr_n;

  // k-th candidate in the round-robin search order starting just after p.
  function automatic logic [PTR_W-1:0] rr_idx(input logic [PTR_W-1:0] p, input int k);
    int s;
    s = (int'(p) + k) % NUM_REQ;
    return PTR_W'(s);
  endfunction
`endif

  // Arbiter: first set request in search order wins.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
`ifdef SYNC_SCHED_FIXED_PRIO_EN
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_valid && REQ[i]) begin
        win_valid = 1'b1;
        win_idx   = PTR_W'(i);
      end
    end
`else
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!win_valid && REQ[rr_idx(rr_ptr, k)]) begin
        win_valid = 1'b1;
        win_idx   = rr_idx(rr_ptr, k);
      end
    end
`endif
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    gnt_n    = '0;
    bus_en_n = 1'b0;
    bus_n    = UN_SYNC_BUS;
`ifndef SYNC_SCHED_FIXED_PRIO_EN
    rr_ptr_n = rr_ptr;
`endif
    case (state)
      IDLE: begin
        if (win_valid) begin
          bus_n    = DATA_IN[win_idx*BUS_WIDTH +: BUS_WIDTH];
          bus_en_n = 1'b1;
          gnt_n    = NUM_REQ'(1) << win_idx;
          cnt_n    = CNT_LOAD;
          state_n  = HOLD;
`ifndef SYNC_SCHED_FIXED_PRIO_EN
          rr_ptr_n = win_idx;
`endif
        end
      end
      HOLD: begin
        // The launch cycle itself is the first HOLD cycle, so the counter
        // starts at HOLD_CYCLES-1 and the exit happens on cnt==0.
        if (cnt != '0) begin
          cnt_n = cnt - CNT_W'(1);
        end else begin
          state_n = IDLE;
        end
      end
    endcase
    busy_n = (state_n == HOLD);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      cnt         <= '0;
      GNT         <= '0;
      UN_SYNC_BUS <= '0;
      BUS_EN      <= 1'b0;
      BUSY        <= 1'b0;
`ifndef SYNC_SCHED_FIXED_PRIO_EN
      rr_ptr      <= PTR_W'(NUM_REQ - 1);
`endif
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      GNT         <= gnt_n;
      UN_SYNC_BUS <= bus_n;
      BUS_EN      <= bus_en_n;
      BUSY        <= busy_n;
`ifndef SYNC_SCHED_FIXED_PRIO_EN
      rr_ptr      <= rr_ptr_n;
`endif
    end
  end

endmodule

// File: tb/tb_sync_tx_scheduler.sv
// tb/tb_sync_tx_scheduler.sv - scoreboard bench for sync_tx_scheduler
module tb_sync_tx_scheduler;

  localparam int N = 4;
  localparam int W = 8;
  localparam int H = 4;

  logic           CLK = 1'b0;
  logic           RST = 1'b0;
  logic [N-1:0]   REQ = '0;
  logic [N*W-1:0] DATA_IN = '0;
  logic [N-1:0]   GNT;
  logic [W-1:0]   UN_SYNC_BUS;
  logic           BUS_EN;
  logic           BUSY;

  sync_tx_scheduler #(.NUM_REQ(N), .BUS_WIDTH(W), .HOLD_CYCLES(H)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .DATA_IN(DATA_IN),
    .GNT(GNT), .UN_SYNC_BUS(UN_SYNC_BUS), .BUS_EN(BUS_EN), .BUSY(BUSY)
  );

  initial forever #5 CLK = ~CLK;

  int cyc = 0;
  initial forever begin
    @(posedge CLK);
    cyc = cyc + 1;
  end

  typedef struct {
    int           cyc;
    logic         en;
    logic [N-1:0] gnt;
    logic [W-1:0] bus;
    logic         busy;
  } exp_t;

  exp_t         exp_q[$];
  logic [N-1:0] gnt_log[$];
  int           launch_log[$];
  int           n_checks = 0;
  int           n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference model: transfer-level view (busy for H cycles, one idle look, then next winner).
  bit           m_busy = 1'b0;
  int           m_hold = 0;
  int           m_last = N - 1;
  logic [W-1:0] m_bus = '0;

  function automatic int pick(input logic [N-1:0] q);
`ifdef SYNC_SCHED_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (q[i]) return i;
`else
    for (int k = 1; k <= N; k++) if (q[(m_last + k) % N]) return (m_last + k) % N;
`endif
    return 0;
  endfunction

  // Drive inputs for the next rising edge and queue the outputs expected after it.
  task automatic step(input logic r, input logic [N-1:0] q, input logic [N*W-1:0] d);
    exp_t e;
    int   w;
    @(negedge CLK);
    #1;
    RST = r;
    REQ = q;
    DATA_IN = d;
    e.cyc  = cyc + 1;
    e.en   = 1'b0;
    e.gnt  = '0;
    e.busy = 1'b0;
    if (r) begin
      m_busy = 1'b0;
      m_hold = 0;
      m_last = N - 1;
      m_bus  = '0;
    end else if (m_busy) begin
      if (m_hold > 0) begin
        m_hold--;
        e.busy = 1'b1;
      end else begin
        m_busy = 1'b0;
      end
    end else if (q != '0) begin
      w      = pick(q);
      m_bus  = d[w*W +: W];
      e.en   = 1'b1;
      e.gnt  = N'(1) << w;
      e.busy = 1'b1;
      m_busy = 1'b1;
      m_hold = H - 1;
      m_last = w;
    end
    e.bus = m_bus;
    exp_q.push_back(e);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt"}, 32'(GNT), 32'h0);
    chk({tag, "_bus_en"}, 32'(BUS_EN), 32'h0);
    chk({tag, "_busy"}, 32'(BUSY), 32'h0);
    chk({tag, "_bus"}, 32'(UN_SYNC_BUS), 32'h0);
  endtask

  // Monitor: compares DUT outputs with the queued expectation for this cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        chk("sb_stale_entry", 32'(e.cyc), 32'(cyc));
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        chk("sb_bus_en", 32'(BUS_EN), 32'(e.en));
        chk("sb_gnt", 32'(GNT), 32'(e.gnt));
        chk("sb_bus", 32'(UN_SYNC_BUS), 32'(e.bus));
        chk("sb_busy", 32'(BUSY), 32'(e.busy));
        if (BUS_EN === 1'b1) begin
          gnt_log.push_back(GNT);
          launch_log.push_back(cyc);
        end
      end
    end
  end

  logic [N*W-1:0] d;
  logic [N-1:0]   seq_exp [5];

  initial begin
    // Reset applied asynchronously, before any clock edge.
    #2;
    REQ = N'($urandom);
    DATA_IN = $urandom;
    RST = 1'b1;
    #1;
    chk_zero("reset_async");
    step(1'b1, N'($urandom), $urandom);
    step(1'b1, N'($urandom), $urandom);
    step(1'b0, '0, '0);
    step(1'b0, '0, '0);

    // Single transfer from requester 0.
    d = {24'($urandom), 8'hC3};
    step(1'b0, 4'b0001, d);
    repeat (7) step(1'b0, 4'b0000, $urandom);
    chk("single_bus_held", 32'(UN_SYNC_BUS), 32'hC3);
    chk("single_gnt", 32'(gnt_log.size() > 0 ? gnt_log[gnt_log.size()-1] : '0), 32'h1);

    // Late request: requester 1 raises REQ during requester 0's hold.
    gnt_log.delete();
    launch_log.delete();
    step(1'b0, 4'b0001, $urandom);
    repeat (5) step(1'b0, 4'b0010, $urandom);
    repeat (3) step(1'b0, 4'b0000, $urandom);
    chk("late_launch_count", 32'(gnt_log.size()), 32'd2);
    if (gnt_log.size() == 2) begin
      chk("late_second_gnt", 32'(gnt_log[1]), 32'b0010);
      chk("late_gap", 32'(launch_log[1] - launch_log[0]), 32'(H + 1));
    end

    // Withdrawal while busy, then reset in the middle of the hold.
    step(1'b0, 4'b0001, $urandom);
    step(1'b0, 4'b0100, $urandom);
    step(1'b0, 4'b0000, $urandom);
    step(1'b1, 4'b0000, $urandom);
    #1;
    chk_zero("reset_mid_hold");
    step(1'b1, 4'b1111, $urandom);

    // Contended requests straight after reset.
    gnt_log.delete();
    launch_log.delete();
`ifdef SYNC_SCHED_FIXED_PRIO_EN
    seq_exp = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010};
    repeat (25) step(1'b0, 4'b1010, 32'hA3A2A1A0);
`else
    seq_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    repeat (25) step(1'b0, 4'b1111, 32'hA3A2A1A0);
`endif
    step(1'b0, 4'b0000, 32'hA3A2A1A0);
    chk("arb_launch_count", 32'(gnt_log.size()), 32'd5);
    for (int i = 0; i < 5 && i < gnt_log.size(); i++) begin
      chk("arb_gnt_seq", 32'(gnt_log[i]), 32'(seq_exp[i]));
      if (i > 0) chk("arb_period", 32'(launch_log[i] - launch_log[i-1]), 32'(H + 1));
    end

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] q;
      q = '0;
      for (int b = 0; b < N; b++) q[b] = ($urandom_range(0, 99) < 35);
      step(($urandom_range(0, 99) == 0), q, $urandom);
    end

    step(1'b0, '0, '0);
    step(1'b0, '0, '0);
    @(negedge CLK);
    #1;
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
